gardner_loop_ctrl: RTL and testbench
====================================

# gardner_loop_ctrl

Sequencing controller for the Gardner timing-recovery loop. It holds the timing corrector in reset, then runs it with a wide acquisition loop gain. It switches to a narrow tracking gain and declares symbol-timing lock from windowed average timing-error magnitude. On sustained loss of lock it re-acquires automatically. It sits beside the 32.768 MHz timing corrector, drives its reset and shift configuration, and consumes its 1.024 MHz symbol strobe and timing error.

## Interface
- WIDTH, 16, timing-error width (signed)
- ACQ_SYMBOLS, 256, symbols spent in acquisition gain (>=1)
- WIN_LOG2, 6, lock-detect window = 2^WIN_LOG2 symbols
- LOCK_WINDOWS, 4, consecutive good windows to declare lock (>=1)
- UNLOCK_WINDOWS, 2, consecutive bad windows in LOCKED to drop lock (>=1)
- FLUSH_CYCLES, 4, clk cycles corr_rst is held in FLUSH (>=1)

Ports:
- clk  in  1  clock (32.768 MHz)
- rst  in  1  reset rst, synchronous, active-high
- enable  in  1  level; 1 = run loop, 0 = park in IDLE
- sym_valid  in  1  one-cycle symbol strobe from corrector
- error_n  in  WIDTH  signed timing error, sampled only when sym_valid=1
- SHIFT_ACQ  in  4  error shift during acquisition
- SHIFT_TRACK  in  4  error shift during tracking/locked
- LOCK_THRESH  in  WIDTH  unsigned average-|error| lock threshold
- gardner_shift  out  4  shift to corrector
- corr_rst  out  1  synchronous reset to corrector
- locked  out  1  timing lock flag
- lock_metric  out  WIDTH  unsigned average |error| of last completed window
- state_out  out  3  current state encoding (debug)

## Operation
- States and encodings: IDLE=0, FLUSH=1, ACQ=2, TRACK=3, LOCKED=4.
- IDLE: corr_rst=1, gardner_shift=SHIFT_ACQ, locked=0. enable=1 -> FLUSH.
- FLUSH: corr_rst=1 for exactly FLUSH_CYCLES cycles, then -> ACQ. sym_cnt, acc, good_cnt and bad_cnt are cleared.
- ACQ: corr_rst=0, gardner_shift=SHIFT_ACQ. sym_valid pulses are counted. On the ACQ_SYMBOLS-th pulse -> TRACK.
- TRACK: gardner_shift=SHIFT_TRACK.
  - Each sym_valid adds |error_n| to acc (WIDTH+WIN_LOG2 bits, unsigned).
  - |x| of the most negative value saturates to 2^(WIDTH-1)-1.
  - On the 2^WIN_LOG2-th pulse of a window, avg = (acc + |error_n|) >> WIN_LOG2, using the current sample. Then lock_metric <= avg, acc <= 0, and the window restarts.
  - If avg < LOCK_THRESH: good_cnt++. Otherwise good_cnt <= 0.
  - When good_cnt reaches LOCK_WINDOWS -> LOCKED.
- LOCKED: locked=1, gardner_shift=SHIFT_TRACK. The same windowing runs.
  - A bad window (avg >= LOCK_THRESH) increments bad_cnt. A good window clears it.
  - When bad_cnt reaches UNLOCK_WINDOWS -> FLUSH and locked <= 0.
- enable=0 in any state -> IDLE at the next edge. All counters and acc are cleared. lock_metric holds its value.
- SHIFT_ACQ and SHIFT_TRACK are not latched. Changes take effect the next cycle.

## Timing
- All outputs are registered. Reset values: gardner_shift=0, corr_rst=1, locked=0, lock_metric=0, state_out=0 (IDLE). After reset, gardner_shift follows SHIFT_ACQ from the first IDLE cycle.
- enable rises at edge N: state=FLUSH and corr_rst=1 from N+1. corr_rst falls at edge N+1+FLUSH_CYCLES, which is also when state=ACQ.
- Window completion and state transitions take effect at the clock edge where the final sym_valid is sampled. lock_metric, locked and gardner_shift update at that same edge, one cycle of latency.
- sym_valid arriving in IDLE or FLUSH is ignored.
- sym_valid coinciding with enable falling: enable has priority, and the sample is discarded.
- Counter widths must hold ACQ_SYMBOLS, 2^WIN_LOG2, LOCK_WINDOWS and UNLOCK_WINDOWS without wrap. acc cannot overflow by construction.
- rst mid-operation: all state returns to reset values at the next edge, regardless of enable.

## Test plan
- Reset/idle. Stimulus: rst for 3 cycles, enable=0, SHIFT_ACQ=8. Required: corr_rst=1, locked=0, state_out=0, gardner_shift=8 from the first post-reset cycle.
- Flush/acquire. Stimulus: enable raised. Required: corr_rst high for exactly 4 cycles. Then ACQ with shift=SHIFT_ACQ. After 256 sym_valid pulses (one per 32 clk), state=TRACK and gardner_shift=SHIFT_TRACK=12.
- Lock. Stimulus: TRACK, error_n alternating ±100, LOCK_THRESH=200. Required: lock_metric=100 after each window. locked=1 at the edge of the 256th tracking symbol (4 windows × 64).
- Threshold edge and saturation. Stimulus: error_n = -32768 every symbol. Required: lock_metric=32767, which is never < LOCK_THRESH=32767, so no lock. Stimulus: avg exactly equal to LOCK_THRESH. Required: the window counts as bad.
- Loss of lock. Stimulus: in LOCKED, one bad window, then one good, then two bad. Required: locked stays 1 until the end of the second consecutive bad window. Then FLUSH with corr_rst=1 and locked=0, followed by re-acquisition.
- Abort. Stimulus: enable dropped mid-window in LOCKED, coinciding with sym_valid. Required: IDLE next cycle, locked=0, corr_rst=1, lock_metric unchanged. On re-enable, a full ACQ is repeated.

Source files
------------

// File: rtl/gardner_loop_ctrl.sv
// Sequencing controller for the Gardner timing-recovery loop: flush, wide-gain
// acquisition, narrow-gain tracking, windowed |error| lock detection and re-acquire.
module gardner_loop_ctrl #(
    parameter int WIDTH          = 16,
    parameter int ACQ_SYMBOLS    = 256,
    parameter int WIN_LOG2       = 6,
    parameter int LOCK_WINDOWS   = 4,
    parameter int UNLOCK_WINDOWS = 2,
    parameter int FLUSH_CYCLES   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    sym_valid,
    input  logic signed [WIDTH-1:0] error_n,
    input  logic [3:0]              SHIFT_ACQ,
    input  logic [3:0]              SHIFT_TRACK,
    input  logic [WIDTH-1:0]        LOCK_THRESH,
    output logic [3:0]              gardner_shift,
    output logic                    corr_rst,
    output logic                    locked,
    output logic [WIDTH-1:0]        lock_metric,
    output logic [2:0]              state_out
);

    localparam int ACC_W  = WIDTH + WIN_LOG2;
    localparam int ACQ_W  = $clog2(ACQ_SYMBOLS + 1);
    localparam int WIN_W  = WIN_LOG2 + 1;
    localparam int CNT_W  = (ACQ_W > WIN_W) ? ACQ_W : WIN_W;
    localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
    localparam int BAD_W  = $clog2(UNLOCK_WINDOWS + 1);
    localparam int FL_W   = $clog2(FLUSH_CYCLES + 1);

    localparam logic [CNT_W-1:0]  ACQ_LAST   = CNT_W'(ACQ_SYMBOLS - 1);
    localparam logic [CNT_W-1:0]  WIN_LAST   = CNT_W'((1 << WIN_LOG2) - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST  = GOOD_W'(LOCK_WINDOWS - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST   = BAD_W'(UNLOCK_WINDOWS - 1);
    localparam logic [FL_W-1:0]   FLUSH_LAST = FL_W'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        ACQ    = 3'd2,
        TRACK  = 3'd3,
        LOCKED = 3'd4
    } state_t;

    // Magnitude with the most negative code clamped so it fits in WIDTH-1 bits.
    function automatic logic [WIDTH-1:0] abs_sat(input logic signed [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        if (x == {1'b1, {(WIDTH-1){1'b0}}}) begin
            r = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (x[WIDTH-1]) begin
            r = -x;
        end else begin
            r = x;
        end
        return r;
    endfunction

    state_t             state_r;
    state_t             state_nx_s;
    logic [CNT_W-1:0]   sym_cnt_r;
    logic [ACC_W-1:0]   acc_r;
    logic [GOOD_W-1:0]  good_cnt_r;
    logic [BAD_W-1:0]   bad_cnt_r;
    logic [FL_W-1:0]    flush_cnt_r;

    logic [WIDTH-1:0]   abs_s;
    logic [ACC_W-1:0]   sum_s;
    logic [ACC_W-1:0]   shifted_s;
    logic [WIDTH-1:0]   avg_s;
    logic               in_win_s;
    logic               win_last_s;
    logic               good_s;

    // Window datapath and next-state decision; enable low overrides everything.
    always_comb begin
        abs_s      = abs_sat(error_n);
        sum_s      = acc_r + ACC_W'(abs_s);
        shifted_s  = sum_s >> WIN_LOG2;
        avg_s      = shifted_s[WIDTH-1:0];
        in_win_s   = (state_r == TRACK) || (state_r == LOCKED);
        win_last_s = sym_valid && in_win_s && (sym_cnt_r == WIN_LAST);
        good_s     = avg_s < LOCK_THRESH;
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable) state_nx_s = FLUSH;
                else        state_nx_s = IDLE;
            end
            FLUSH: begin
                if (flush_cnt_r == FLUSH_LAST) state_nx_s = ACQ;
                else                           state_nx_s = FLUSH;
            end
            ACQ: begin
                if (sym_valid && (sym_cnt_r == ACQ_LAST)) state_nx_s = TRACK;
                else                                      state_nx_s = ACQ;
            end
            TRACK: begin
                if (win_last_s && good_s && (good_cnt_r == GOOD_LAST)) state_nx_s = LOCKED;
                else                                                   state_nx_s = TRACK;
            end
            LOCKED: begin
                if (win_last_s && !good_s && (bad_cnt_r == BAD_LAST)) state_nx_s = FLUSH;
                else                                                  state_nx_s = LOCKED;
            end
            default: state_nx_s = IDLE;
        endcase
        if (!enable) begin
            state_nx_s = IDLE;
        end else begin
            state_nx_s = state_nx_s;
        end
    end

    // State, counters and registered outputs; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            sym_cnt_r     <= '0;
            acc_r         <= '0;
            good_cnt_r    <= '0;
            bad_cnt_r     <= '0;
            flush_cnt_r   <= '0;
            gardner_shift <= 4'd0;
            corr_rst      <= 1'b1;
            locked        <= 1'b0;
            lock_metric   <= '0;
            state_out     <= 3'd0;
        end else begin
            state_r       <= state_nx_s;
            state_out     <= state_nx_s;
            corr_rst      <= (state_nx_s == IDLE) || (state_nx_s == FLUSH);
            locked        <= (state_nx_s == LOCKED);
            gardner_shift <= ((state_nx_s == TRACK) || (state_nx_s == LOCKED)) ? SHIFT_TRACK : SHIFT_ACQ;
            if (enable && win_last_s) begin
                lock_metric <= avg_s;
            end
            // Every state change (and IDLE itself) starts counting from scratch.
            if ((state_nx_s != state_r) || (state_r == IDLE)) begin
                sym_cnt_r   <= '0;
                acc_r       <= '0;
                good_cnt_r  <= '0;
                bad_cnt_r   <= '0;
                flush_cnt_r <= '0;
            end else begin
                case (state_r)
                    FLUSH: flush_cnt_r <= flush_cnt_r + FL_W'(1);
                    ACQ: begin
                        if (sym_valid) sym_cnt_r <= sym_cnt_r + CNT_W'(1);
                    end
                    TRACK, LOCKED: begin
                        if (win_last_s) begin
                            acc_r     <= '0;
                            sym_cnt_r <= '0;
                            if (state_r == TRACK) begin
                                good_cnt_r <= good_s ? (good_cnt_r + GOOD_W'(1)) : '0;
                            end else begin
                                bad_cnt_r  <= good_s ? '0 : (bad_cnt_r + BAD_W'(1));
                            end
                        end else if (sym_valid) begin
                            acc_r     <= sum_s;
                            sym_cnt_r <= sym_cnt_r + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gardner_loop_ctrl.sv
// Directed bench for gardner_loop_ctrl: one table row per lock-detect window,
// plus hand-written reset, flush, re-acquire and abort sequences.
module tb_gardner_loop_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               sym_valid;
    logic signed [15:0] error_n;
    logic [3:0]         SHIFT_ACQ;
    logic [3:0]         SHIFT_TRACK;
    logic [15:0]        LOCK_THRESH;
    logic [3:0]         gardner_shift;
    logic               corr_rst;
    logic               locked;
    logic [15:0]        lock_metric;
    logic [2:0]         state_out;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    gardner_loop_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable), .sym_valid(sym_valid),
        .error_n(error_n), .SHIFT_ACQ(SHIFT_ACQ), .SHIFT_TRACK(SHIFT_TRACK),
        .LOCK_THRESH(LOCK_THRESH), .gardner_shift(gardner_shift),
        .corr_rst(corr_rst), .locked(locked), .lock_metric(lock_metric),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int err_a;
        int err_b;
        int thresh;
        int exp_metric;
        bit exp_locked;
        int exp_state;
        bit exp_corr;
        bit reacq;
    } win_vec_t;

    win_vec_t tbl[20];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_sym(input int e, input int gap);
        error_n   = 16'(e);
        sym_valid = 1'b1;
        step();
        sym_valid = 1'b0;
        repeat (gap - 1) step();
    endtask

    task automatic wait_state(input int target, input int limit);
        int n = 0;
        while (state_out != 3'(target) && n < limit) begin
            step();
            n++;
        end
        check("wait_state", int'(state_out), target);
    endtask

    // Flush must end in ACQ; a full ACQ_SYMBOLS of pulses is needed to reach TRACK.
    task automatic reacquire(input int gap);
        wait_state(2, 20);
        repeat (255) send_sym(0, gap);
        check("acq_not_done", int'(state_out), 2);
        send_sym(0, gap);
        check("acq_done_state", int'(state_out), 3);
        check("acq_done_shift", int'(gardner_shift), 12);
    endtask

    task automatic run_window(input win_vec_t v, input int idx);
        LOCK_THRESH = 16'(v.thresh);
        for (int i = 0; i < 63; i++) send_sym((i % 2 == 0) ? v.err_a : v.err_b, 4);
        error_n   = 16'(v.err_b);
        sym_valid = 1'b1;
        step();
        sym_valid = 1'b0;
        check($sformatf("win%0d_metric", idx), int'(lock_metric), v.exp_metric);
        check($sformatf("win%0d_locked", idx), int'(locked), int'(v.exp_locked));
        check($sformatf("win%0d_state", idx), int'(state_out), v.exp_state);
        check($sformatf("win%0d_corr_rst", idx), int'(corr_rst), int'(v.exp_corr));
        check($sformatf("win%0d_shift", idx), int'(gardner_shift),
              (v.exp_state == 3 || v.exp_state == 4) ? 12 : 8);
        repeat (3) step();
    endtask

    initial begin
        int n;
        tbl[0]  = '{100, -100, 200, 100, 1'b0, 3, 1'b0, 1'b0};
        tbl[1]  = '{100, -100, 200, 100, 1'b0, 3, 1'b0, 1'b0};
        tbl[2]  = '{100, -100, 200, 100, 1'b0, 3, 1'b0, 1'b0};
        tbl[3]  = '{100, -100, 200, 100, 1'b1, 4, 1'b0, 1'b0};
        tbl[4]  = '{300, -300, 200, 300, 1'b1, 4, 1'b0, 1'b0};
        tbl[5]  = '{100, -100, 200, 100, 1'b1, 4, 1'b0, 1'b0};
        tbl[6]  = '{300, -300, 200, 300, 1'b1, 4, 1'b0, 1'b0};
        tbl[7]  = '{300, -300, 200, 300, 1'b0, 1, 1'b1, 1'b1};
        tbl[8]  = '{-32768, -32768, 32767, 32767, 1'b0, 3, 1'b0, 1'b0};
        tbl[9]  = '{-32768, -32768, 32767, 32767, 1'b0, 3, 1'b0, 1'b0};
        tbl[10] = '{-32768, -32768, 32767, 32767, 1'b0, 3, 1'b0, 1'b0};
        tbl[11] = '{-32768, -32768, 32767, 32767, 1'b0, 3, 1'b0, 1'b0};
        tbl[12] = '{101, -100, 500, 100, 1'b0, 3, 1'b0, 1'b0};
        tbl[13] = '{100, -100, 500, 100, 1'b0, 3, 1'b0, 1'b0};
        tbl[14] = '{100, -100, 500, 100, 1'b0, 3, 1'b0, 1'b0};
        tbl[15] = '{500, -500, 500, 500, 1'b0, 3, 1'b0, 1'b0};
        tbl[16] = '{499, -499, 500, 499, 1'b0, 3, 1'b0, 1'b0};
        tbl[17] = '{100, -100, 500, 100, 1'b0, 3, 1'b0, 1'b0};
        tbl[18] = '{100, -100, 500, 100, 1'b0, 3, 1'b0, 1'b0};
        tbl[19] = '{100, -100, 500, 100, 1'b1, 4, 1'b0, 1'b0};

        rst = 1'b1; enable = 1'b0; sym_valid = 1'b0; error_n = '0;
        SHIFT_ACQ = 4'd8; SHIFT_TRACK = 4'd12; LOCK_THRESH = 16'd200;
        repeat (3) step();
        check("rst_shift", int'(gardner_shift), 0);
        check("rst_corr_rst", int'(corr_rst), 1);
        check("rst_locked", int'(locked), 0);
        check("rst_metric", int'(lock_metric), 0);
        check("rst_state", int'(state_out), 0);
        rst = 1'b0;
        step();
        check("idle_shift", int'(gardner_shift), 8);
        check("idle_state", int'(state_out), 0);
        check("idle_corr_rst", int'(corr_rst), 1);

        enable = 1'b1;
        step();
        n = 0;
        while (state_out == 3'd1 && n < 20) begin
            check("flush_corr_rst", int'(corr_rst), 1);
            n++;
            step();
        end
        check("flush_cycles", n, 4);
        check("acq_state", int'(state_out), 2);
        check("acq_corr_rst", int'(corr_rst), 0);
        check("acq_shift", int'(gardner_shift), 8);
        SHIFT_ACQ = 4'd5;
        step();
        check("acq_shift_live", int'(gardner_shift), 5);
        SHIFT_ACQ = 4'd8;
        step();
        repeat (255) send_sym(0, 32);
        check("acq255_state", int'(state_out), 2);
        send_sym(0, 32);
        check("track_state", int'(state_out), 3);
        check("track_shift", int'(gardner_shift), 12);

        for (int i = 0; i < 20; i++) begin
            run_window(tbl[i], i);
            if (tbl[i].reacq) reacquire(4);
        end

        // Abort on the 64th symbol of a LOCKED window with a huge error: it must be discarded.
        LOCK_THRESH = 16'd500;
        for (int i = 0; i < 63; i++) send_sym((i % 2 == 0) ? 100 : -100, 4);
        enable = 1'b0; error_n = 16'sd30000; sym_valid = 1'b1;
        step();
        sym_valid = 1'b0;
        check("abort_state", int'(state_out), 0);
        check("abort_locked", int'(locked), 0);
        check("abort_corr_rst", int'(corr_rst), 1);
        check("abort_metric", int'(lock_metric), 100);
        check("abort_shift", int'(gardner_shift), 8);
        repeat (5) send_sym(0, 3);
        check("idle_ignores_sym", int'(state_out), 0);
        enable = 1'b1;
        step();
        send_sym(0, 1);
        check("flush_ignores_sym", int'(state_out), 1);
        reacquire(4);

        // Synchronous reset mid-operation with enable still high.
        repeat (5) send_sym(1000, 4);
        rst = 1'b1;
        step();
        check("midrst_state", int'(state_out), 0);
        check("midrst_metric", int'(lock_metric), 0);
        check("midrst_shift", int'(gardner_shift), 0);
        check("midrst_corr_rst", int'(corr_rst), 1);
        rst = 1'b0; enable = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
